muldiv_seq: RTL

//  Iterative multiply/divide sequencer owning the HI/LO result path next to the ALU in EX.

---
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit for the HI/LO path: shift-add multiply, restoring divide,
// WIDTH iterations per op, then one sign-fix cycle and a single-cycle HI/LO write strobe.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             we_hi,
  output logic             we_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign in_signed = ~op[0];
  assign a_neg     = in_signed & srcA[WIDTH-1];
  assign b_neg     = in_signed & srcB[WIDTH-1];
  assign a_abs     = a_neg ? -srcA : srcA;
  assign b_abs     = b_neg ? -srcB : srcB;

  // Multiplier sits in the low half of prod_q and shifts out as the product shifts in.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);

  // Partial remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
  assign div_shift = {rem_q, prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];

  assign mul_res   = neg_quo_q ? -prod_q : prod_q;
  assign quo_res   = neg_quo_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_res   = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    stall_req   = 1'b0;
    we_hi       = 1'b0;
    we_lo       = 1'b0;
    div_by_zero = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          stall_req = 1'b1;
          is_div_d  = op[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          a_d       = a_abs;
          b_d       = b_abs;
          cnt_d     = '0;
          rem_d     = '0;
          prod_d    = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          if (op[1] && (srcB == '0)) begin
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            dz_d    = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (is_div_q) begin
          prod_d[WIDTH-1:0] = {prod_q[WIDTH-2:0], div_ge};
          rem_d             = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        stall_req = 1'b1;
        if (is_div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          {hi_d, lo_d} = mul_res;
        end
        state_d = StDone;
      end
      StDone: begin
        if (dz_q) begin
          div_by_zero = 1'b1;
        end else begin
          we_hi = 1'b1;
          we_lo = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Squash: abandon the op without touching HI/LO or raising any strobe.
    if (flush) begin
      state_d     = StIdle;
      hi_d        = hi_q;
      lo_d        = lo_q;
      we_hi       = 1'b0;
      we_lo       = 1'b0;
      div_by_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
